// File: rtl/philv_pkg.sv
// Shared defaults, counter width and checker FSM encoding for the PHILV result checker.
package philv_pkg;

  localparam int PHILV_N           = 32;
  localparam int PHILV_INSTR_WIDTH = 32;
  localparam int PHILV_CNT_W       = 16;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [PHILV_CNT_W-1:0] sat_inc(input logic [PHILV_CNT_W-1:0] v);
    return (v == '1) ? v : v + PHILV_CNT_W'(1);
  endfunction

endpackage

// File: rtl/philv_sync_fifo.sv
// Single-clock FIFO holding mismatch records; head word is visible combinationally on pop_data.
module philv_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Pointers carry one extra lap bit so full and empty are distinguishable.
  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign pop_data  = r_mem[r_rd_ptr[AW-1:0]];

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage has no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/philv_result_checker.sv
// Compares core results against expected values, counts beats and mismatches,
// and queues mismatch records for a downstream consumer before declaring the test done.
module philv_result_checker
  import philv_pkg::*;
#(
  parameter int N           = PHILV_N,
  parameter int INSTR_WIDTH = PHILV_INSTR_WIDTH,
  parameter int ERR_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   res_valid,
  output logic                   res_ready,
  input  logic [INSTR_WIDTH-1:0] res_instr,
  input  logic [N-1:0]           res_a,
  input  logic [N-1:0]           res_b,
  input  logic [N-1:0]           res_c,
  input  logic [N-1:0]           res_c_x,
  input  logic                   res_last,
  output logic                   err_valid,
  input  logic                   err_ready,
  output logic [INSTR_WIDTH-1:0] err_instr,
  output logic [N-1:0]           err_c,
  output logic [N-1:0]           err_c_x,
  output logic [PHILV_CNT_W-1:0] vec_count,
  output logic [PHILV_CNT_W-1:0] err_count,
  output logic                   done,
  output logic                   pass
);

  localparam int REC_W = INSTR_WIDTH + 2 * N;

  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic                   r_armed;
  logic [PHILV_CNT_W-1:0] r_vec_count;
  logic [PHILV_CNT_W-1:0] r_err_count;
  logic                   w_accept;
  logic                   w_mismatch;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic [REC_W-1:0]       w_push_rec;
  logic [REC_W-1:0]       w_head_rec;
  logic                   w_unused_ops;

  // Operands travel with the beat for trace purposes only; the verdict depends on c versus c_x.
  assign w_unused_ops = ^{res_a, res_b};

  // r_armed keeps ready low through reset and the first edge after it is released.
  assign res_ready  = r_armed && (r_state == ST_RUN) && !w_full;
  assign w_accept   = res_valid && res_ready;
  assign w_mismatch = w_accept && (res_c != res_c_x);
  assign w_pop      = err_valid && err_ready;
  assign w_push_rec = {res_instr, res_c, res_c_x};

  assign err_valid = !w_empty;
  assign err_instr = w_head_rec[REC_W-1 -: INSTR_WIDTH];
  assign err_c     = w_head_rec[2*N-1 -: N];
  assign err_c_x   = w_head_rec[N-1:0];

  assign vec_count = r_vec_count;
  assign err_count = r_err_count;
  assign done      = (r_state == ST_DONE);
  assign pass      = done && (r_err_count == '0);

  // NOTE: the default assignment before the case keeps this block free of inferred latches.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (w_accept && res_last) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_empty) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_DONE;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_armed     <= 1'b0;
      r_vec_count <= '0;
      r_err_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_armed <= 1'b1;
      if (w_accept)   r_vec_count <= sat_inc(r_vec_count);
      if (w_mismatch) r_err_count <= sat_inc(r_err_count);
    end
  end

  // Ready drops while the FIFO is full, so a mismatch push is never refused.
  philv_sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (ERR_DEPTH)
  ) u_err_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_mismatch),
    .push_data (w_push_rec),
    .pop       (w_pop),
    .pop_data  (w_head_rec),
    .full      (w_full),
    .empty     (w_empty)
  );

endmodule

// File: tb/tb_philv_result_checker.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed literal scenarios.
module tb_philv_result_checker;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        res_valid = 1'b0;
  logic        res_ready;
  logic [31:0] res_instr = '0;
  logic [31:0] res_a = '0;
  logic [31:0] res_b = '0;
  logic [31:0] res_c = '0;
  logic [31:0] res_c_x = '0;
  logic        res_last = 1'b0;
  logic        err_valid;
  logic        err_ready = 1'b0;
  logic [31:0] err_instr;
  logic [31:0] err_c;
  logic [31:0] err_c_x;
  logic [15:0] vec_count;
  logic [15:0] err_count;
  logic        done;
  logic        pass;

  always #5 clk = ~clk;

  philv_result_checker #(
    .N           (32),
    .INSTR_WIDTH (32),
    .ERR_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_instr (res_instr),
    .res_a     (res_a),
    .res_b     (res_b),
    .res_c     (res_c),
    .res_c_x   (res_c_x),
    .res_last  (res_last),
    .err_valid (err_valid),
    .err_ready (err_ready),
    .err_instr (err_instr),
    .err_c     (err_c),
    .err_c_x   (err_c_x),
    .vec_count (vec_count),
    .err_count (err_count),
    .done      (done),
    .pass      (pass)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] c;
    logic [31:0] cx;
  } rec_t;

  typedef enum int { M_RUN, M_DRAIN, M_DONE } mphase_t;

  rec_t    m_q[$];
  int      m_vec = 0;
  int      m_err = 0;
  mphase_t m_phase = M_RUN;
  bit      m_armed = 1'b0;
  bit      m_acc;
  bit      m_pop;
  bit      m_was_empty;
  bit      m_rdy;

  int n_checks = 0;
  int n_errors = 0;
  bit rand_er = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a beat is taken when offered while running, not in reset's shadow and
  // the record queue has room; mismatches join the queue; the test ends once the queue is empty.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_vec   = 0;
      m_err   = 0;
      m_phase = M_RUN;
      m_armed = 1'b0;
    end else begin
      m_acc       = res_valid && m_armed && (m_phase == M_RUN) && (m_q.size() < DEPTH);
      m_pop       = err_ready && (m_q.size() > 0);
      m_was_empty = (m_q.size() == 0);
      if (m_pop) m_q.delete(0);
      if (m_acc) begin
        if (m_vec < 65535) m_vec++;
        if (res_c != res_c_x) begin
          if (m_err < 65535) m_err++;
          m_q.push_back('{res_instr, res_c, res_c_x});
        end
      end
      if (m_phase == M_RUN && m_acc && res_last) m_phase = M_DRAIN;
      else if (m_phase == M_DRAIN && m_was_empty) m_phase = M_DONE;
      m_armed = 1'b1;
    end
  end

  always @(negedge clk) begin
    m_rdy = !rst && m_armed && (m_phase == M_RUN) && (m_q.size() < DEPTH);
    check("res_ready", res_ready, m_rdy);
    check("err_valid", err_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      check("err_instr", err_instr, m_q[0].instr);
      check("err_c", err_c, m_q[0].c);
      check("err_c_x", err_c_x, m_q[0].cx);
    end
    check("vec_count", vec_count, m_vec);
    check("err_count", err_count, m_err);
    check("done", done, m_phase == M_DONE);
    check("pass", pass, (m_phase == M_DONE) && (m_err == 0));
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_er) err_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_beat(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] cx, input logic last);
    int waited;
    bit got;
    waited    = 0;
    got       = 1'b0;
    res_valid = 1'b1;
    res_instr = instr;
    res_a     = a;
    res_b     = b;
    res_c     = c;
    res_c_x   = cx;
    res_last  = last;
    while (!got && waited <= 300) begin
      @(negedge clk);
      if (res_ready === 1'b1) got = 1'b1;
      tick();
      waited++;
    end
    if (!got) check("ready_timeout", res_ready, 1);
    res_valid = 1'b0;
    res_last  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (done !== 1'b1 && k < 300) begin
      tick();
      @(negedge clk);
      k++;
    end
    check(name, done, 1);
    tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst       = 1'b1;
    rand_er   = 1'b0;
    res_valid = 1'b0;
    res_last  = 1'b0;
    err_ready = 1'b0;
    #1;
    check("rst_vec", vec_count, 0);
    check("rst_err", err_count, 0);
    check("rst_err_valid", err_valid, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_ready", res_ready, 0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rst_release_ready", res_ready, 0);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int          nb;
    int          nmis;
    int          gap;
    logic [31:0] c;
    logic [31:0] cx;

    // Power-on reset state.
    @(negedge clk);
    check("por_vec", vec_count, 0);
    check("por_err_valid", err_valid, 0);
    check("por_done", done, 0);
    check("por_pass", pass, 0);
    check("por_ready", res_ready, 0);
    #2;
    rst = 1'b0;
    #1;
    check("por_release_ready", res_ready, 0);
    tick();

    // Ten matching beats: done and pass two cycles after the last accept.
    err_ready = 1'b1;
    for (int i = 0; i < 10; i++)
      send_beat(32'h1000 + i, i, i + 1, i * 3, i * 3, i == 9);
    @(negedge clk);
    check("t42_drain_done", done, 0);
    check("t42_vec", vec_count, 10);
    tick();
    @(negedge clk);
    check("t42_done", done, 1);
    check("t42_pass", pass, 1);
    check("t42_vec_final", vec_count, 10);
    check("t42_err", err_count, 0);
    tick();

    // One mismatch on beat 3 (c=5, c_x=6).
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        send_beat(32'hC0DE0003, 7, 8, 5, 6, 1'b0);
        @(negedge clk);
        check("t43_err_valid", err_valid, 1);
        check("t43_err_instr", err_instr, 32'hC0DE0003);
        check("t43_err_c", err_c, 5);
        check("t43_err_c_x", err_c_x, 6);
        tick();
        err_ready = 1'b1;
      end else begin
        send_beat(32'hC0DE0000 + i, i, i, i, i, i == 9);
      end
    end
    wait_done("t43_done");
    check("t43_err_count", err_count, 1);
    check("t43_pass", pass, 0);

    // Five mismatches with no consumer: back-pressure, then a held DRAIN.
    do_reset();
    for (int i = 0; i < 4; i++)
      send_beat(32'h4400 + i, 0, 0, i, i + 100, 1'b0);
    @(negedge clk);
    check("t44_full_ready", res_ready, 0);
    tick();
    res_valid = 1'b1;
    res_instr = 32'h4404;
    res_c     = 32'd4;
    res_c_x   = 32'd104;
    res_last  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t44_blocked_ready", res_ready, 0);
      check("t44_blocked_vec", vec_count, 4);
      tick();
    end
    err_ready = 1'b1;
    tick();
    err_ready = 1'b0;
    @(negedge clk);
    check("t44_ready_after_pop", res_ready, 1);
    tick();
    res_valid = 1'b0;
    res_last  = 1'b0;
    @(negedge clk);
    check("t44_err_count", err_count, 5);
    check("t44_vec_count", vec_count, 5);
    tick();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t45_hold_drain", done, 0);
      tick();
    end
    err_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t45_draining", done, 0);
      tick();
    end
    @(negedge clk);
    check("t45_done", done, 1);
    check("t45_pass", pass, 0);
    check("t45_err_count", err_count, 5);
    tick();

    // Reset mid-test with two records queued, then a fresh 3-beat test.
    do_reset();
    for (int i = 0; i < 6; i++)
      send_beat(32'h4600 + i, 0, 0, i, (i == 1 || i == 4) ? i + 1 : i, 1'b0);
    @(negedge clk);
    check("t46_queued", err_valid, 1);
    check("t46_pre_vec", vec_count, 6);
    tick();
    do_reset();
    err_ready = 1'b1;
    for (int i = 0; i < 3; i++)
      send_beat(32'h4610 + i, 0, 0, 9, 9, i == 2);
    wait_done("t46_done");
    check("t46_vec", vec_count, 3);
    check("t46_pass", pass, 1);

    // Simultaneous push and pop at occupancy 2.
    do_reset();
    send_beat(32'h4701, 0, 0, 1, 2, 1'b0);
    send_beat(32'h4702, 0, 0, 3, 4, 1'b0);
    res_valid = 1'b1;
    res_instr = 32'h4703;
    res_c     = 32'd5;
    res_c_x   = 32'd6;
    err_ready = 1'b1;
    @(negedge clk);
    check("t47_ready", res_ready, 1);
    check("t47_head0", err_instr, 32'h4701);
    tick();
    res_valid = 1'b0;
    err_ready = 1'b0;
    @(negedge clk);
    check("t47_head1", err_instr, 32'h4702);
    check("t47_head1_c", err_c, 3);
    tick();
    err_ready = 1'b1;
    tick();
    err_ready = 1'b0;
    @(negedge clk);
    check("t47_head2", err_instr, 32'h4703);
    check("t47_head2_cx", err_c_x, 6);
    tick();
    err_ready = 1'b1;
    tick();
    err_ready = 1'b0;
    @(negedge clk);
    check("t47_empty", err_valid, 0);
    tick();

    // Randomized tests with a randomly stalling consumer.
    for (int t = 0; t < 8; t++) begin
      do_reset();
      rand_er = 1'b1;
      nb      = $urandom_range(4, 30);
      nmis    = 0;
      for (int i = 0; i < nb; i++) begin
        gap = $urandom_range(0, 2);
        repeat (gap) tick();
        c  = $urandom();
        cx = ($urandom_range(0, 2) == 0) ? (c ^ (32'h1 << $urandom_range(0, 31))) : c;
        if (c != cx) nmis++;
        send_beat($urandom(), $urandom(), $urandom(), c, cx, i == nb - 1);
      end
      wait_done("rand_done");
      check("rand_vec", vec_count, nb);
      check("rand_err", err_count, nmis);
      check("rand_pass", pass, nmis == 0);
    end
    rand_er = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/philv_result_checker.md
PHILV_RESULT_CHECKER -- requirements
Module: philv_result_checker

Interface
REQ-001 Parameter N, default 32, data operand/result width.
REQ-002 Parameter INSTR_WIDTH, default 32, instruction width.
REQ-003 Parameter ERR_DEPTH, default 4, mismatch-record FIFO depth, power of two, at least 2.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 res_valid  in  1  result beat offered by the core side.
REQ-007 res_ready  out  1  checker accepts the beat this cycle.
REQ-008 res_instr  in  INSTR_WIDTH  instruction of the beat.
REQ-009 res_a, res_b  in  N each  operands of the beat.
REQ-010 res_c  in  N  core result.
REQ-011 res_c_x  in  N  expected result.
REQ-012 res_last  in  1  final beat of the test.
REQ-013 err_valid  out  1  mismatch record available.
REQ-014 err_ready  in  1  consumer takes the record.
REQ-015 err_instr, err_c, err_c_x  out  INSTR_WIDTH/N/N  head mismatch record.
REQ-016 vec_count, err_count  out  16 each  accepted beats, mismatching beats.
REQ-017 done  out  1  test complete and all records drained.
REQ-018 pass  out  1  done with zero mismatches.

Function
REQ-019 A beat is accepted on a rising edge where res_valid and res_ready are both 1.
REQ-020 res_ready = (state == RUN) and the error FIFO is not full; no combinational path from res_valid to res_ready.
REQ-021 Each accepted beat increments vec_count by 1, saturating at 16'hFFFF.
REQ-022 An accepted beat with res_c != res_c_x (full N-bit compare) is a mismatch.
REQ-023 A mismatch increments err_count by 1, saturating at 16'hFFFF.
REQ-024 A mismatch pushes {res_instr, res_c, res_c_x} into the error FIFO.
REQ-025 No mismatch is ever dropped; back-pressure via REQ-020 guarantees this.
REQ-026 err_valid = FIFO not empty; err_* show the head record.
REQ-027 The head record pops on a rising edge with err_valid and err_ready both 1.
REQ-028 Push-to-err_valid latency is 1 cycle; no same-cycle bypass.
REQ-029 Simultaneous push and pop on a non-empty FIFO leaves its occupancy unchanged.
REQ-030 FIFO read/write pointers wrap modulo ERR_DEPTH.
REQ-031 States: RUN, DRAIN, DONE.
REQ-032 RUN -> DRAIN on an accepted beat with res_last=1; that beat is counted and checked normally.
REQ-033 DRAIN -> DONE on the first cycle the FIFO is empty, including the cycle immediately after entry if nothing was queued.
REQ-034 DONE holds until reset; beats are not accepted in DRAIN or DONE.
REQ-035 done = (state == DONE); pass = done and (err_count == 0).
REQ-036 Counters and FIFO do not change in DONE.

Reset
REQ-037 rst=1 immediately forces state=RUN, FIFO empty, vec_count=0, err_count=0, done=0, pass=0 and err_valid=0.
REQ-038 While rst=1, res_ready=0.
REQ-039 Reset asserted mid-test discards all queued records and in-flight counts; no beat is accepted in the cycle rst deasserts.

Structure
REQ-040 The shared package philv_pkg holds N and INSTR_WIDTH defaults and the RUN/DRAIN/DONE state encoding.
REQ-041 The error FIFO is a sub-module, philv_sync_fifo (parameters WIDTH and DEPTH; outputs full and empty), instantiated once.

Verification
REQ-042 Ten matching beats, last on the tenth, err_ready=1 -> vec_count=10, err_count=0, done=1 and pass=1 two cycles after the last accept.
REQ-043 Beat 3 with c=5 and c_x=6 among ten beats -> one record {instr, 5, 6} on err_valid one cycle after accept; err_count=1; pass=0.
REQ-044 err_ready=0 and five consecutive mismatches -> res_ready=0 after the fourth push; the fifth is accepted only after one pop; err_count=5 and no record is lost.
REQ-045 Last beat is a mismatch with err_ready=0 -> state holds in DRAIN with done=0; raising err_ready gives done=1 the cycle after the FIFO empties.
REQ-046 rst pulsed after 6 beats with 2 records queued -> all outputs zero immediately; a new 3-beat test gives vec_count=3.
REQ-047 Push and pop in the same cycle with occupancy 2 -> occupancy stays 2; record order is preserved.
